hyster_window_gen: RTL and testbench

//  Converts a raster-order stream of quantised edge-strength pixels into 3x3 neighbourhood windows.

---
 rtl/hyster_window_gen_if.sv | 29 ++
 rtl/hyster_window_gen.sv | 194 +++++++++++++++++++
 tb/tb_hyster_window_gen.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/hyster_window_gen_if.sv
// Pixel-stream input and 3x3-window output bundle for hyster_window_gen.
// master = pixel source / window consumer side, slave = the window generator.
interface hyster_window_gen_if #(
    parameter int DSIZE = 4,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic               i_sof;
    logic               i_valid;
    logic [DSIZE-1:0]   i_pixel;
    logic               o_ready;
    logic               o_valid;
    logic [DSIZE*9-1:0] o_window;
    logic [XW-1:0]      o_x;
    logic [YW-1:0]      o_y;

    modport master (
        output i_sof, i_valid, i_pixel,
        input  o_ready, o_valid, o_window, o_x, o_y
    );

    modport slave (
        input  i_sof, i_valid, i_pixel,
        output o_ready, o_valid, o_window, o_x, o_y
    );
endinterface

// File: rtl/hyster_window_gen.sv
// Raster pixel stream to zero-padded 3x3 windows, one per frame pixel, for the
// hysteresis thresholding stage. Two line buffers plus a 3x3 shift window.
module hyster_window_gen #(
    parameter int DSIZE = 4,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic              i_clk,
    input  logic              i_rst,
    hyster_window_gen_if.slave bus
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int NW = $clog2(IMG_W * IMG_H + IMG_W + 2);
    localparam int WW = DSIZE * 9;

    localparam logic [NW-1:0] N_FILL_END  = NW'(IMG_W);
    localparam logic [NW-1:0] N_LAST      = NW'(IMG_W * IMG_H - 1);
    localparam logic [NW-1:0] N_FLUSH_END = NW'(IMG_W * IMG_H + IMG_W);
    localparam logic [XW-1:0] X_LAST      = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST      = YW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    // Zero the neighbours of (x,y) that lie outside the frame; p0 is the MSB slot.
    function automatic logic [WW-1:0] pad_window(input logic [WW-1:0] win,
                                                 input logic [XW-1:0] x,
                                                 input logic [YW-1:0] y);
        logic [WW-1:0] res;
        res = win;
        for (int i = 0; i < 9; i++) begin
            if (((i % 3 == 0) && (x == '0)) || ((i % 3 == 2) && (x == X_LAST)) ||
                ((i / 3 == 0) && (y == '0)) || ((i / 3 == 2) && (y == Y_LAST)))
                res[WW-1-DSIZE*i -: DSIZE] = '0;
        end
        return res;
    endfunction

    state_t            state_q, state_d;
    logic [NW-1:0]     n_q, n_d;
    logic [XW-1:0]     col_q, col_d;
    logic [XW-1:0]     cx_q, cx_d;
    logic [YW-1:0]     cy_q, cy_d;
    logic              o_valid_q, o_valid_d;
    logic [WW-1:0]     o_window_q, o_window_d;
    logic [XW-1:0]     o_x_q, o_x_d;
    logic [YW-1:0]     o_y_q, o_y_d;

    logic [DSIZE-1:0]  win_q [0:8];
    logic [DSIZE-1:0]  win_d [0:8];
    logic [DSIZE-1:0]  lb_a_q [0:IMG_W-1];
    logic [DSIZE-1:0]  lb_b_q [0:IMG_W-1];

    logic              accept;
    logic              step;
    logic              restart;
    logic              emit;
    logic [DSIZE-1:0]  pix;
    logic [XW-1:0]     wr_col;
    logic [WW-1:0]     win_pk;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        col_d      = col_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        o_valid_d  = 1'b0;
        o_window_d = o_window_q;
        o_x_d      = o_x_q;
        o_y_d      = o_y_q;
        step       = 1'b0;
        restart    = 1'b0;
        emit       = 1'b0;
        pix        = '0;
        win_d      = win_q;
        win_pk     = '0;
        accept     = bus.i_valid && (state_q != FLUSH);

        case (state_q)
            IDLE: begin
                if (accept && bus.i_sof)
                    restart = 1'b1;
            end
            FILL, RUN: begin
                if (accept) begin
                    if (bus.i_sof) begin
                        restart = 1'b1;
                    end else begin
                        step = 1'b1;
                        pix  = bus.i_pixel;
                        n_d  = n_q + 1'b1;
                        if (state_q == FILL && n_q == N_FILL_END)
                            state_d = RUN;
                        if (state_q == RUN) begin
                            emit = 1'b1;
                            if (n_q == N_LAST)
                                state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                // Zero pixels push the last rows through the window.
                step = 1'b1;
                emit = 1'b1;
                n_d  = n_q + 1'b1;
                if (n_q == N_FLUSH_END)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // An accepted sof always becomes pixel (0,0) of a fresh frame.
        if (restart) begin
            step    = 1'b1;
            pix     = bus.i_pixel;
            n_d     = NW'(1);
            cx_d    = '0;
            cy_d    = '0;
            state_d = FILL;
        end

        wr_col = restart ? '0 : col_q;
        if (step) begin
            col_d    = (wr_col == X_LAST) ? '0 : wr_col + 1'b1;
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = lb_b_q[wr_col];
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = lb_a_q[wr_col];
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = pix;
        end

        for (int i = 0; i < 9; i++)
            win_pk[WW-1-DSIZE*i -: DSIZE] = win_d[i];

        // Freshly shifted window is centred IMG_W+1 pixels behind the input.
        if (emit) begin
            o_valid_d  = 1'b1;
            o_window_d = pad_window(win_pk, cx_q, cy_q);
            o_x_d      = cx_q;
            o_y_d      = cy_q;
            if (cx_q == X_LAST) begin
                cx_d = '0;
                cy_d = (cy_q == Y_LAST) ? '0 : cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            col_q      <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            o_valid_q  <= 1'b0;
            o_window_q <= '0;
            o_x_q      <= '0;
            o_y_q      <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            col_q      <= col_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            o_valid_q  <= o_valid_d;
            o_window_q <= o_window_d;
            o_x_q      <= o_x_d;
            o_y_q      <= o_y_d;
        end
    end

    // Pixel storage needs no reset; stale contents are always padded or shifted out.
    always_ff @(posedge i_clk) begin
        win_q <= win_d;
        if (step) begin
            lb_a_q[wr_col] <= pix;
            lb_b_q[wr_col] <= lb_a_q[wr_col];
        end
    end

    assign bus.o_ready  = (state_q != FLUSH);
    assign bus.o_valid  = o_valid_q;
    assign bus.o_window = o_window_q;
    assign bus.o_x      = o_x_q;
    assign bus.o_y      = o_y_q;
endmodule

// File: tb/tb_hyster_window_gen.sv
// Directed bench for hyster_window_gen on a 4x3 frame of 4-bit pixels.
module tb_hyster_window_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hyster_window_gen_if #(.DSIZE(4), .IMG_W(4), .IMG_H(3)) bus ();

    hyster_window_gen #(.DSIZE(4), .IMG_W(4), .IMG_H(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    logic [1:0]  q_x   [$];
    logic [1:0]  q_y   [$];
    logic [35:0] q_win [$];
    int          q_cyc [$];
    logic [3:0]  fr    [12];
    int          last_acc_cyc;

    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) begin
            q_x.push_back(bus.o_x);
            q_y.push_back(bus.o_y);
            q_win.push_back(bus.o_window);
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] ref_win(input int x, input int y);
        logic [35:0] r;
        logic [3:0]  v;
        int          xx, yy;
        r = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                xx = x + dx;
                yy = y + dy;
                v  = (xx >= 0 && xx < 4 && yy >= 0 && yy < 3) ? fr[yy*4 + xx] : 4'h0;
                r  = {r[31:0], v};
            end
        end
        return r;
    endfunction

    task automatic clear_q();
        q_x.delete();
        q_y.delete();
        q_win.delete();
        q_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            bus.i_sof   = 1'b0;
        end
    endtask

    task automatic send(input logic [3:0] pix, input logic sof, input bit gaps);
        int waited;
        waited = 0;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1 && waited < 8) begin
                @(negedge clk);
                bus.i_valid = 1'b0;
                bus.i_sof   = 1'b0;
                waited++;
            end
        end
        waited = 0;
        @(negedge clk);
        while (bus.o_ready !== 1'b1 && waited < 50) begin
            bus.i_valid = 1'b0;
            @(negedge clk);
            waited++;
        end
        if (bus.o_ready !== 1'b1) chk("ready_timeout", 64'(bus.o_ready), 64'd1);
        bus.i_valid  = 1'b1;
        bus.i_sof    = sof;
        bus.i_pixel  = pix;
        last_acc_cyc = cyc + 1;
    endtask

    // Holds i_valid high with junk during flush; returns the number of not-ready cycles.
    task automatic run_flush(output int lows);
        lows = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.o_ready === 1'b1) break;
            lows++;
            bus.i_valid = 1'b1;
            bus.i_sof   = 1'b0;
            bus.i_pixel = 4'hF;
        end
        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_count"}, 64'(q_win.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < q_win.size())
                chk($sformatf("%s_w%0d", tag, i), {24'd0, q_x[i], q_y[i], q_win[i]},
                    {24'd0, 2'(i % 4), 2'(i / 4), ref_win(i % 4, i / 4)});
        end
    endtask

    task automatic send_frame(input int base, input bit rev, input bit gaps);
        for (int i = 0; i < 12; i++) begin
            fr[i] = rev ? 4'(11 - i) : 4'(base + i);
            send(fr[i], (i == 0), gaps);
        end
    endtask

    initial begin
        int lows, nf, acc5, acc11;
        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
        bus.i_pixel = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_valid",  64'(bus.o_valid),  64'd0);
        chk("rst_window", 64'(bus.o_window), 64'd0);
        chk("rst_ready",  64'(bus.o_ready),  64'd1);
        chk("rst_x",      64'(bus.o_x),      64'd0);
        chk("rst_y",      64'(bus.o_y),      64'd0);
        rst = 1'b0;
        idle(2);

        // back-to-back frame, values = raster index
        clear_q();
        acc5  = 0;
        acc11 = 0;
        for (int i = 0; i < 12; i++) begin
            fr[i] = 4'(i);
            send(4'(i), (i == 0), 1'b0);
            if (i == 5)  acc5  = last_acc_cyc;
            if (i == 11) acc11 = last_acc_cyc;
        end
        run_flush(lows);
        chk("flush_not_ready_cycles", 64'(lows), 64'd5);
        idle(2);
        check_frame("frame_b2b");
        if (q_win.size() >= 12) begin
            chk("first_window_latency", 64'(q_cyc[0]), 64'(acc5));
            chk("first_window_val", 64'(q_win[0]), 64'h000001045);
            chk("centre_1_1_val",   64'(q_win[5]), 64'h01245689A);
            chk("centre_3_2_val",   64'(q_win[11]), 64'h670AB0000);
            chk("centre_6_on_last_accept", 64'(q_cyc[6]), 64'(acc11));
            nf = 0;
            foreach (q_cyc[k]) if (q_cyc[k] > acc11) nf++;
            chk("flush_windows", 64'(nf), 64'd5);
        end
        // back in IDLE: pixels without sof are dropped
        send(4'h5, 1'b0, 1'b0);
        send(4'h6, 1'b0, 1'b0);
        idle(6);
        chk("idle_drops_non_sof", 64'(q_win.size()), 64'd12);

        // random valid gaps
        clear_q();
        send_frame(0, 1'b0, 1'b1);
        run_flush(lows);
        chk("gap_flush_cycles", 64'(lows), 64'd5);
        idle(2);
        check_frame("frame_gaps");

        // sof in the middle of a frame restarts it
        clear_q();
        for (int i = 0; i < 7; i++) send(4'(i), (i == 0), 1'b0);
        idle(2);
        clear_q();
        send_frame(3, 1'b0, 1'b0);
        run_flush(lows);
        idle(2);
        check_frame("frame_abort");
        if (q_win.size() >= 1)
            chk("abort_first_window_val", 64'(q_win[0]), 64'h000034078);

        // reset in the middle of flush
        send_frame(0, 1'b0, 1'b0);
        idle(2);
        chk("flush_active_before_rst", 64'(bus.o_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("flush_rst_valid",  64'(bus.o_valid),  64'd0);
        chk("flush_rst_window", 64'(bus.o_window), 64'd0);
        chk("flush_rst_ready",  64'(bus.o_ready),  64'd1);
        idle(1);
        clear_q();
        send_frame(0, 1'b1, 1'b0);
        run_flush(lows);
        idle(2);
        check_frame("frame_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
